cpu_irq_responder: RTL and testbench

//   CPU-side responder to the intc IRQ/ADDR/IACK interface. At an instruction boundary it

---
 rtl/cpu_irq_responder_pkg.sv | 31 +++
 rtl/cpu_irq_responder_iack_pulse_gen.sv | 38 +++
 rtl/cpu_irq_responder.sv | 156 +++++++++++++++
 tb/tb_cpu_irq_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_irq_responder_pkg.sv
// Shared definitions for the CPU-side interrupt responder: FSM encoding,
// the intc ISR vector map and counter sizing helpers.
package cpu_irq_responder_pkg;

    // Responder states; encodings match the ones the intc side uses.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TAKE      = 3'd1,
        ST_ACK       = 3'd2,
        ST_WAIT_DROP = 3'd3,
        ST_SERVICE   = 3'd4,
        ST_RETURN    = 3'd5
    } irq_state_e;

    // ISR vectors handed out by intc on its ADDR bus.
    localparam logic [31:0] ISR_VEC_0 = 32'h0003_0000;
    localparam logic [31:0] ISR_VEC_1 = 32'h0004_0000;
    localparam logic [31:0] ISR_VEC_2 = 32'h0005_0000;
    localparam logic [31:0] ISR_VEC_3 = 32'h0006_0000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One timer serves both the IACK width and the drop timeout, so it is
    // sized for the larger of the two load values.
    function automatic int cnt_width(input int iack_cycles, input int ack_timeout);
        return $clog2(max_int(iack_cycles, ack_timeout) + 1);
    endfunction

endpackage

// File: rtl/cpu_irq_responder_iack_pulse_gen.sv
// Load / count-down timer. A load wins over a decrement; the count
// saturates at zero so it can never wrap.
module iack_pulse_gen #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load, saturating decrement, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_irq_responder.sv
// CPU-side responder to the intc IRQ/ADDR/IACK handshake. Takes an interrupt
// at an instruction boundary, saves the return PC, redirects fetch to the ISR
// vector, acknowledges intc, and redirects back to the saved PC on ERET.
// One ISR at a time; all outputs are registered.
module cpu_irq_responder
    import cpu_irq_responder_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int IACK_CYCLES = 1,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq,
    input  logic [ADDR_W-1:0] isr_addr,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              instr_boundary,
    input  logic              eret,
    input  logic              int_en,
    output logic              iack,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] epc,
    output logic              in_isr,
    output logic              ack_err
);

    localparam int               CNT_W     = cnt_width(IACK_CYCLES, ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] IACK_LOAD = CNT_W'(IACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD  = CNT_W'(ACK_TIMEOUT - 1);

    irq_state_e        state_q, state_d;
    logic              eret_pend_q, eret_pend_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] redirect_addr_q, redirect_addr_d;
    logic              pc_redirect_q, pc_redirect_d;
    logic              iack_q, iack_d;
    logic              in_isr_q, in_isr_d;
    logic              ack_err_q, ack_err_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_dec;
    logic              tmr_zero;

    iack_pulse_gen #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state logic; outputs are derived from the state being entered so
    // they are registered yet line up with the state they belong to.
    always_comb begin
        state_d         = state_q;
        eret_pend_d     = eret_pend_q;
        epc_d           = epc_q;
        redirect_addr_d = redirect_addr_q;
        ack_err_d       = ack_err_q;
        tmr_load        = 1'b0;
        tmr_val         = '0;
        tmr_dec         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (irq && int_en && instr_boundary) begin
                    state_d         = ST_TAKE;
                    epc_d           = pc_next;
                    redirect_addr_d = isr_addr;
                end
            end
            ST_TAKE: begin
                if (eret) eret_pend_d = 1'b1;
                state_d  = ST_ACK;
                tmr_load = 1'b1;
                tmr_val  = IACK_LOAD;
            end
            ST_ACK: begin
                if (eret) eret_pend_d = 1'b1;
                if (tmr_zero) begin
                    state_d  = ST_WAIT_DROP;
                    tmr_load = 1'b1;
                    tmr_val  = TMO_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT_DROP: begin
                if (eret) eret_pend_d = 1'b1;
                if (!irq) begin
                    state_d = ST_SERVICE;
                end else if (tmr_zero) begin
                    // intc never released the request; flag it and move on
                    // so the CPU is not stalled.
                    ack_err_d = 1'b1;
                    state_d   = ST_SERVICE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (eret || eret_pend_q) begin
                    state_d         = ST_RETURN;
                    eret_pend_d     = 1'b0;
                    redirect_addr_d = epc_q;
                end
            end
            ST_RETURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pc_redirect_d = (state_d == ST_TAKE) || (state_d == ST_RETURN);
        iack_d        = (state_d == ST_ACK);
        in_isr_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset abandons any ISR in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            eret_pend_q     <= 1'b0;
            epc_q           <= '0;
            redirect_addr_q <= '0;
            pc_redirect_q   <= 1'b0;
            iack_q          <= 1'b0;
            in_isr_q        <= 1'b0;
            ack_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            eret_pend_q     <= eret_pend_d;
            epc_q           <= epc_d;
            redirect_addr_q <= redirect_addr_d;
            pc_redirect_q   <= pc_redirect_d;
            iack_q          <= iack_d;
            in_isr_q        <= in_isr_d;
            ack_err_q       <= ack_err_d;
        end
    end

    assign iack          = iack_q;
    assign pc_redirect   = pc_redirect_q;
    assign redirect_addr = redirect_addr_q;
    assign epc           = epc_q;
    assign in_isr        = in_isr_q;
    assign ack_err       = ack_err_q;

endmodule

// File: tb/tb_cpu_irq_responder.sv
// Self-checking bench for cpu_irq_responder: randomized PCs, vectors and
// eret placement against a per-cycle timeline of the interrupt sequence.
module tb_cpu_irq_responder;

    localparam int ADDR_W      = 32;
    localparam int IACK_CYCLES = 2;
    localparam int ACK_TIMEOUT = 16;
    localparam logic [31:0] VEC [4] = '{32'h0003_0000, 32'h0004_0000,
                                        32'h0005_0000, 32'h0006_0000};

    logic              clk;
    logic              rst_n;
    logic              irq;
    logic [ADDR_W-1:0] isr_addr;
    logic [ADDR_W-1:0] pc_next;
    logic              instr_boundary;
    logic              eret;
    logic              int_en;
    logic              iack;
    logic              pc_redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] epc;
    logic              in_isr;
    logic              ack_err;

    int n_vec;
    int n_err;

    cpu_irq_responder #(
        .ADDR_W      (ADDR_W),
        .IACK_CYCLES (IACK_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq            (irq),
        .isr_addr       (isr_addr),
        .pc_next        (pc_next),
        .instr_boundary (instr_boundary),
        .eret           (eret),
        .int_en         (int_en),
        .iack           (iack),
        .pc_redirect    (pc_redirect),
        .redirect_addr  (redirect_addr),
        .epc            (epc),
        .in_isr         (in_isr),
        .ack_err        (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'($urandom()) & 32'hFFFF_FFFC;
    endfunction

    // Present a request at a boundary and step into the TAKE cycle; afterwards
    // scramble inputs that must no longer matter.
    task automatic start_take(input logic [31:0] vec, input logic [31:0] pc);
        irq            = 1'b1;
        isr_addr       = vec;
        pc_next        = pc;
        int_en         = 1'b1;
        instr_boundary = 1'b1;
        tick();
        instr_boundary = 1'b0;
        int_en         = 1'($urandom_range(0, 1));
        isr_addr       = rand_pc();
        pc_next        = rand_pc();
    endtask

    // From the TAKE cycle: release irq, return through SERVICE/RETURN to IDLE.
    task automatic finish_isr();
        irq = 1'b0;
        repeat (IACK_CYCLES + 2) tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        irq = 1'b0; int_en = 1'b0; instr_boundary = 1'b0; eret = 1'b0;
        isr_addr = '0; pc_next = '0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({iack, pc_redirect, in_isr, ack_err} !== 4'b0 || redirect_addr !== '0 || epc !== '0) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got flags=%b addr=%h epc=%h want flags=0000 addr=0 epc=0",
                         i, {iack, pc_redirect, in_isr, ack_err}, redirect_addr, epc);
            end
            if (i == 1) rst_n = 1'b1;
            tick();
        end
    endtask

    task automatic test_basic_take();
        logic [31:0] vec, pc;
        int w;
        for (int it = 0; it < 4; it++) begin
            vec = (it == 0) ? 32'h0005_0000 : VEC[$urandom_range(0, 3)];
            pc  = (it == 0) ? 32'h0000_1000 : rand_pc();
            start_take(vec, pc);
            n_vec++;
            if ({pc_redirect, iack, in_isr} !== 3'b101 || redirect_addr !== vec || epc !== pc) begin
                n_err++;
                $display("FAIL basic_take[%0d]: got r/i/s=%b addr=%h epc=%h want 101 addr=%h epc=%h",
                         it, {pc_redirect, iack, in_isr}, redirect_addr, epc, vec, pc);
            end
            for (int k = 1; k <= IACK_CYCLES; k++) begin
                tick();
                n_vec++;
                if ({pc_redirect, iack, in_isr} !== 3'b011) begin
                    n_err++;
                    $display("FAIL basic_iack[%0d.%0d]: got r/i/s=%b want 011", it, k, {pc_redirect, iack, in_isr});
                end
                if (k == IACK_CYCLES) irq = 1'b0;
            end
            w = $urandom_range(2, 5);
            for (int k = 0; k < w; k++) begin
                tick();
                n_vec++;
                if ({pc_redirect, iack, in_isr} !== 3'b001) begin
                    n_err++;
                    $display("FAIL basic_service[%0d.%0d]: got r/i/s=%b want 001", it, k, {pc_redirect, iack, in_isr});
                end
            end
            eret = 1'b1;
            tick();
            eret = 1'b0;
            n_vec++;
            if ({pc_redirect, iack, in_isr} !== 3'b101 || redirect_addr !== pc) begin
                n_err++;
                $display("FAIL basic_return[%0d]: got r/i/s=%b addr=%h want 101 addr=%h",
                         it, {pc_redirect, iack, in_isr}, redirect_addr, pc);
            end
            tick();
            n_vec++;
            if ({pc_redirect, iack, in_isr} !== 3'b000 || epc !== pc) begin
                n_err++;
                $display("FAIL basic_idle[%0d]: got r/i/s=%b epc=%h want 000 epc=%h",
                         it, {pc_redirect, iack, in_isr}, epc, pc);
            end
        end
    endtask

    task automatic test_gating();
        logic [31:0] vec, pc;
        int r;
        vec = VEC[$urandom_range(0, 3)];
        irq = 1'b1;
        isr_addr = vec;
        for (int c = 0; c < 20; c++) begin
            r = $urandom_range(0, 2);
            int_en         = (r == 2);
            instr_boundary = (r == 1);
            pc_next        = rand_pc();
            tick();
            n_vec++;
            if ({pc_redirect, iack, in_isr} !== 3'b000) begin
                n_err++;
                $display("FAIL gating[%0d]: got r/i/s=%b want 000 (en=%b bnd=%b)",
                         c, {pc_redirect, iack, in_isr}, int_en, instr_boundary);
            end
        end
        pc = rand_pc();
        start_take(vec, pc);
        n_vec++;
        if (pc_redirect !== 1'b1 || redirect_addr !== vec || epc !== pc) begin
            n_err++;
            $display("FAIL gating_take: got r=%b addr=%h epc=%h want 1 addr=%h epc=%h",
                     pc_redirect, redirect_addr, epc, vec, pc);
        end
        finish_isr();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc_a, pc_b;
        int w;
        pc_a = rand_pc();
        pc_b = rand_pc();
        start_take(32'h0006_0000, pc_a);
        irq = 1'b0;
        repeat (IACK_CYCLES + 2) tick();
        irq = 1'b1; isr_addr = 32'h0004_0000; int_en = 1'b1; instr_boundary = 1'b1;
        w = $urandom_range(3, 8);
        for (int k = 0; k < w; k++) begin
            pc_next = rand_pc();
            tick();
            n_vec++;
            if ({pc_redirect, iack, in_isr} !== 3'b001 || epc !== pc_a) begin
                n_err++;
                $display("FAIL b2b_ignored[%0d]: got r/i/s=%b epc=%h want 001 epc=%h",
                         k, {pc_redirect, iack, in_isr}, epc, pc_a);
            end
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_vec++;
        if (pc_redirect !== 1'b1 || redirect_addr !== pc_a) begin
            n_err++;
            $display("FAIL b2b_return: got r=%b addr=%h want 1 addr=%h", pc_redirect, redirect_addr, pc_a);
        end
        tick();
        n_vec++;
        if ({pc_redirect, iack, in_isr} !== 3'b000) begin
            n_err++;
            $display("FAIL b2b_no_take_in_return: got r/i/s=%b want 000", {pc_redirect, iack, in_isr});
        end
        pc_next = pc_b;
        tick();
        instr_boundary = 1'b0;
        n_vec++;
        if (pc_redirect !== 1'b1 || redirect_addr !== 32'h0004_0000 || epc !== pc_b) begin
            n_err++;
            $display("FAIL b2b_retake: got r=%b addr=%h epc=%h want 1 addr=00040000 epc=%h",
                     pc_redirect, redirect_addr, epc, pc_b);
        end
        finish_isr();
    endtask

    // Timeline from the TAKE cycle (s=0): ACK for s=1..IACK_CYCLES, one
    // WAIT_DROP, one SERVICE, RETURN, then IDLE -- for any eret placed up to SERVICE.
    task automatic test_early_eret();
        logic [31:0] vec, pc;
        logic [2:0] exp_ris;
        int p;
        for (int it = 0; it < 4; it++) begin
            vec = VEC[$urandom_range(0, 3)];
            pc  = rand_pc();
            p   = (it == 0) ? 1 : $urandom_range(0, IACK_CYCLES + 2);
            start_take(vec, pc);
            irq = 1'b0;
            for (int s = 0; s <= IACK_CYCLES + 4; s++) begin
                exp_ris = {(s == 0) || (s == IACK_CYCLES + 3),
                           (s >= 1) && (s <= IACK_CYCLES),
                           (s <= IACK_CYCLES + 3)};
                n_vec++;
                if ({pc_redirect, iack, in_isr} !== exp_ris ||
                    (s == IACK_CYCLES + 3 && redirect_addr !== pc)) begin
                    n_err++;
                    $display("FAIL early_eret[%0d] s=%0d p=%0d: got r/i/s=%b addr=%h want %b addr=%h",
                             it, s, p, {pc_redirect, iack, in_isr}, redirect_addr, exp_ris, pc);
                end
                eret = (s == p);
                if (s < IACK_CYCLES + 4) tick();
            end
            eret = 1'b0;
        end
    endtask

    task automatic test_stuck_irq();
        logic [31:0] pc, pc2;
        pc  = rand_pc();
        pc2 = rand_pc();
        n_vec++;
        if (ack_err !== 1'b0) begin
            n_err++;
            $display("FAIL stuck_pre: got ack_err=%b want 0", ack_err);
        end
        start_take(VEC[$urandom_range(0, 3)], pc);
        repeat (IACK_CYCLES) tick();
        for (int n = 0; n <= ACK_TIMEOUT; n++) begin
            tick();
            n_vec++;
            if (ack_err !== (n >= ACK_TIMEOUT) || iack !== 1'b0 || in_isr !== 1'b1) begin
                n_err++;
                $display("FAIL stuck_timeout n=%0d: got err=%b iack=%b in_isr=%b want err=%b iack=0 in_isr=1",
                         n, ack_err, iack, in_isr, (n >= ACK_TIMEOUT));
            end
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        n_vec++;
        if (pc_redirect !== 1'b1 || redirect_addr !== pc || ack_err !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_return: got r=%b addr=%h err=%b want 1 addr=%h err=1",
                     pc_redirect, redirect_addr, ack_err, pc);
        end
        irq = 1'b0;
        tick();
        start_take(VEC[$urandom_range(0, 3)], pc2);
        n_vec++;
        if (pc_redirect !== 1'b1 || epc !== pc2 || ack_err !== 1'b1) begin
            n_err++;
            $display("FAIL stuck_next_take: got r=%b epc=%h err=%b want 1 epc=%h err=1",
                     pc_redirect, epc, ack_err, pc2);
        end
        finish_isr();
        n_vec++;
        if (ack_err !== 1'b1 || in_isr !== 1'b0) begin
            n_err++;
            $display("FAIL stuck_sticky: got err=%b in_isr=%b want err=1 in_isr=0", ack_err, in_isr);
        end
    endtask

    task automatic test_reset_mid_isr();
        logic [31:0] vec, pc;
        start_take(VEC[$urandom_range(0, 3)], rand_pc());
        irq = 1'b0;
        repeat (IACK_CYCLES + 2) tick();
        n_vec++;
        if (in_isr !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre: got in_isr=%b want 1", in_isr);
        end
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({iack, pc_redirect, in_isr, ack_err} !== 4'b0 || redirect_addr !== '0 || epc !== '0) begin
            n_err++;
            $display("FAIL rst_mid_async: got flags=%b addr=%h epc=%h want 0000 0 0",
                     {iack, pc_redirect, in_isr, ack_err}, redirect_addr, epc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({iack, pc_redirect, in_isr, ack_err} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_mid_idle: got flags=%b want 0000", {iack, pc_redirect, in_isr, ack_err});
        end
        vec = VEC[$urandom_range(0, 3)];
        pc  = rand_pc();
        start_take(vec, pc);
        n_vec++;
        if (pc_redirect !== 1'b1 || redirect_addr !== vec || epc !== pc) begin
            n_err++;
            $display("FAIL rst_mid_retake: got r=%b addr=%h epc=%h want 1 addr=%h epc=%h",
                     pc_redirect, redirect_addr, epc, vec, pc);
        end
        finish_isr();
        n_vec++;
        if ({iack, pc_redirect, in_isr, ack_err} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_mid_done: got flags=%b want 0000", {iack, pc_redirect, in_isr, ack_err});
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_take();
        test_gating();
        test_back_to_back();
        test_early_eret();
        test_stuck_irq();
        test_reset_mid_isr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
